// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Front end of the pipelined datapath. Owns the PC, drives the word-aligned
//   byte address to an asynchronous-read instruction memory, and registers the
//   returned word plus PC+4 into the IF/ID pipeline register. Handles
//   load-use stalls, branch/jump redirects (one bubble each) and out-of-range
//   fetch faults (sticky).
//
// Optional feature macro: IFETCH_PERF_EN
//   When defined, adds o_fetch_count / o_stall_count, saturating counters.
//
// Ports
//   i_clk              rising-edge clock
//   i_rst_n            asynchronous active-low reset
//   i_stall            hold PC and IF/ID
//   i_branch_taken     branch resolved taken (beats jump)
//   i_branch_target    branch destination byte address
//   i_jump             j/jal/jr resolved
//   i_jump_target      jump destination byte address
//   i_instruction      memory word for o_address, same cycle
//   o_address          current PC (low two bits always 0)
//   o_ifid_instruction registered instruction
//   o_ifid_pc_plus4    registered PC+4 of that instruction
//   o_ifid_valid       IF/ID holds a real instruction
//   o_fetch_fault      sticky out-of-range fetch flag
//   o_fetch_count      (IFETCH_PERF_EN) edges loading a valid instruction
//   o_stall_count      (IFETCH_PERF_EN) edges stalled without redirect
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_instruction,
  output logic [31:0] o_address,
  output logic [31:0] o_ifid_instruction,
  output logic [31:0] o_ifid_pc_plus4,
  output logic        o_ifid_valid,
`ifdef IFETCH_PERF_EN
  output logic        o_fetch_fault,
  output logic [31:0] o_fetch_count,
  output logic [31:0] o_stall_count
`else
  output logic        o_fetch_fault
`endif
);

  typedef enum logic {S_RESET_HOLD = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_ifid_instr, w_ifid_instr_nxt;
  logic [31:0] r_ifid_pc4, w_ifid_pc4_nxt;
  logic        r_ifid_valid, w_ifid_valid_nxt;
  logic        r_fault, w_fault_nxt;
  logic        w_load_valid;   // this edge loads IF/ID with a real instruction
  logic        w_stall_cnt;    // this edge is a stall not overridden by redirect

  logic [31:0] w_pc_plus4;
  logic        w_oob;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_oob      = {2'b00, r_pc[31:2]} >= 32'(IMEM_WORDS);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_RESET_HOLD;
    else          r_state <= w_state_nxt;
  end

  // Next-state: any edge with reset released lands in RUN
  always_comb begin
    w_state_nxt = S_RUN;
  end

  // Output / datapath-next logic. The first edge out of RESET_HOLD already
  // fetches from RESET_PC, so both states use the same update rules.
  always_comb begin
    w_pc_nxt         = r_pc;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_pc4_nxt   = r_ifid_pc4;
    w_ifid_valid_nxt = r_ifid_valid;
    w_fault_nxt      = r_fault;
    w_load_valid     = 1'b0;
    w_stall_cnt      = 1'b0;
    case (r_state)
      S_RESET_HOLD, S_RUN: begin
        if (i_branch_taken || i_jump) begin
          // Branch is the older instruction, so it wins over a same-cycle jump
          w_pc_nxt         = (i_branch_taken ? i_branch_target : i_jump_target)
                             & ~32'd3;
          w_ifid_instr_nxt = '0;
          w_ifid_pc4_nxt   = '0;
          w_ifid_valid_nxt = 1'b0;
        end else if (i_stall) begin
          w_stall_cnt = 1'b1;
        end else begin
          w_pc_nxt = w_pc_plus4;
          if (w_oob) begin
            // PC keeps advancing; only the captured slot is suppressed
            w_ifid_instr_nxt = '0;
            w_ifid_pc4_nxt   = '0;
            w_ifid_valid_nxt = 1'b0;
            w_fault_nxt      = 1'b1;
          end else begin
            w_ifid_instr_nxt = i_instruction;
            w_ifid_pc4_nxt   = w_pc_plus4;
            w_ifid_valid_nxt = 1'b1;
            w_load_valid     = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc         <= RESET_PC & ~32'd3;
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc4   <= w_ifid_pc4_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_fault      <= w_fault_nxt;
    end
  end

  assign o_address          = r_pc;
  assign o_ifid_instruction = r_ifid_instr;
  assign o_ifid_pc_plus4    = r_ifid_pc4;
  assign o_ifid_valid       = r_ifid_valid;
  assign o_fetch_fault      = r_fault;

`ifdef IFETCH_PERF_EN
  logic [31:0] r_fetch_cnt, r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_load_valid && r_fetch_cnt != 32'hFFFF_FFFF) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall_cnt  && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_fetch_count = r_fetch_cnt;
  assign o_stall_count = r_stall_cnt;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_load_valid ^ w_stall_cnt;
`endif

endmodule
